// File: rtl/register_bank_sweep_pkg.sv
// Shared definitions for the register bank: sweep FSM encoding and fill words.
package register_bank_sweep_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam int MAX_BITS = 32;

    // Sliced down to NrOfBits by the users.
    localparam logic [MAX_BITS-1:0] FILL_ZEROS = '0;
    localparam logic [MAX_BITS-1:0] FILL_ONES  = '1;

endpackage

// File: rtl/register_bank_sweep_ctrl.sv
// Sweep controller: walks ptr 0..Depth-1 writing the latched fill word, one entry per en edge.
// Busy is registered; start is a combinational strobe on the accepting edge; no backpressure.
module register_bank_sweep_ctrl
    import register_bank_sweep_pkg::*;
#(
    parameter int NrOfBits = 8,
    parameter int Depth    = 16,
    parameter int AddrBits = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                clr_req_i,
    input  logic                pre_req_i,
    output logic                start_o,
    output logic                busy_o,
    output logic                sweep_we_o,
    output logic [AddrBits-1:0] sweep_addr_o,
    output logic [NrOfBits-1:0] sweep_data_o
);

    localparam logic [AddrBits-1:0] LAST = AddrBits'(Depth - 1);

    state_e              state_q, state_d;
    logic [AddrBits-1:0] ptr_q, ptr_d;
    logic [NrOfBits-1:0] fill_q, fill_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        start_o    = 1'b0;
        sweep_we_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && (clr_req_i || pre_req_i)) begin
                    start_o = 1'b1;
                    // Clear takes precedence when both requests arrive together.
                    fill_d  = clr_req_i ? FILL_ZEROS[NrOfBits-1:0] : FILL_ONES[NrOfBits-1:0];
                    ptr_d   = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (en_i) begin
                    sweep_we_o = 1'b1;
                    if (ptr_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + AddrBits'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o       = (state_q == SWEEP);
    assign sweep_addr_o = ptr_q;
    assign sweep_data_o = fill_q;

endmodule

// File: rtl/register_bank_sweep.sv
// Depth x NrOfBits register bank, one write port, 1-clock registered read, sweep clear/preset.
// Reads/writes are dropped while Busy or on a sweep-start edge; cs only gates the outputs.
module register_bank_sweep
    import register_bank_sweep_pkg::*;
#(
    parameter  int NrOfBits = 8,
    parameter  int Depth    = 16,
    localparam int AddrBits = $clog2(Depth)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                cs,
    input  logic                WrEn,
    input  logic [AddrBits-1:0] WrAddr,
    input  logic [NrOfBits-1:0] WrData,
    input  logic                RdEn,
    input  logic [AddrBits-1:0] RdAddr,
    output logic [NrOfBits-1:0] RdData,
    output logic                RdValid,
    input  logic                ClrReq,
    input  logic                PreReq,
    output logic                Busy
);

    localparam logic [AddrBits:0] DEPTH_W = (AddrBits + 1)'(Depth);

    logic                en;
    logic                start;
    logic                busy;
    logic                sweep_we;
    logic [AddrBits-1:0] sweep_addr;
    logic [NrOfBits-1:0] sweep_data;
    logic                wr_in_range, rd_in_range;
    logic                user_we, rd_fire;
    logic [NrOfBits-1:0] rd_word;

    logic [NrOfBits-1:0] mem_q [Depth];
    logic [NrOfBits-1:0] rd_data_q;
    logic                rd_valid_q;

    assign en = ClockEnable & Tick;

    register_bank_sweep_ctrl #(
        .NrOfBits (NrOfBits),
        .Depth    (Depth),
        .AddrBits (AddrBits)
    ) u_ctrl (
        .clk_i        (Clock),
        .rst_i        (Reset),
        .en_i         (en),
        .clr_req_i    (ClrReq),
        .pre_req_i    (PreReq),
        .start_o      (start),
        .busy_o       (busy),
        .sweep_we_o   (sweep_we),
        .sweep_addr_o (sweep_addr),
        .sweep_data_o (sweep_data)
    );

    assign wr_in_range = ({1'b0, WrAddr} < DEPTH_W);
    assign rd_in_range = ({1'b0, RdAddr} < DEPTH_W);
    assign user_we     = en & WrEn & wr_in_range & ~busy & ~start;
    assign rd_fire     = en & RdEn & ~busy & ~start;
    assign rd_word     = rd_in_range ? mem_q[RdAddr] : '0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sweep_we) begin
            mem_q[sweep_addr] <= sweep_data;
        end else if (user_we) begin
            mem_q[WrAddr] <= WrData;
        end
    end

    // Valid is re-evaluated every clock so it is a single-cycle pulse even with Tick low.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign RdData  = cs ? '0 : rd_data_q;
    assign RdValid = ~cs & rd_valid_q;
    assign Busy    = busy;

endmodule
